// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Issue-hazard unit for a multi-lane in-order pipeline. It keeps a pending-latency
//   counter per architectural register, a serialisation drain counter, and it
//   qualifies issue on the multiply/divide ready flag. Each cycle it grants the
//   longest in-order prefix of eligible decode lanes.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   lane_valid         lane i holds a decoded instruction
//   srca/srcb/dst      per-lane register addresses, lane i at [i*RAW +: RAW]
//   usea/useb          lane reads srca/srcb
//   regwrite           lane writes dst
//   lat                per-lane result latency (0 = next-cycle bypass)
//   serial             serialising op (hi/lo/cp0 write, tlbr, tlbp)
//   mult_ok            multdiv unit idle or result ready
//   freeze             backend stall, holds all state
//   flush              redirect, clears all state
//   issue_num          number of lanes issued (lanes 0..issue_num-1)
//   stallD             decode/fetch must hold
//   flushE             bubble inserted into execute
//   busy               any counter nonzero
module hazard_scoreboard #(
    parameter int ISSUE_W   = 2,
    parameter int NREG      = 32,
    parameter int RAW       = 5,
    parameter int LAT_W     = 3,
    parameter int SER_DRAIN = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ISSUE_W-1:0]         lane_valid,
    input  logic [ISSUE_W*RAW-1:0]     srca,
    input  logic [ISSUE_W*RAW-1:0]     srcb,
    input  logic [ISSUE_W-1:0]         usea,
    input  logic [ISSUE_W-1:0]         useb,
    input  logic [ISSUE_W*RAW-1:0]     dst,
    input  logic [ISSUE_W-1:0]         regwrite,
    input  logic [ISSUE_W*LAT_W-1:0]   lat,
    input  logic [ISSUE_W-1:0]         serial,
    input  logic                       mult_ok,
    input  logic                       freeze,
    input  logic                       flush,
    output logic [$clog2(ISSUE_W+1)-1:0] issue_num,
    output logic                       stallD,
    output logic                       flushE,
    output logic                       busy
);

    localparam int NUM_W = $clog2(ISSUE_W + 1);
    localparam int SER_W = $clog2(SER_DRAIN + 1);

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [SER_W-1:0] ser_cnt_q;
    logic [SER_W-1:0] ser_cnt_d;

    logic [ISSUE_W-1:0] elig;
    logic [ISSUE_W-1:0] issued;
    logic [NUM_W-1:0]   num_issue;
    logic [NUM_W-1:0]   num_valid;
    logic               busy_raw;

    // Per-lane eligibility, evaluated against registered counters only.
    always_comb begin
        elig = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            logic [RAW-1:0]   sa, sb, di, dj;
            logic [LAT_W-1:0] li;
            logic             ok;
            sa = srca[i*RAW +: RAW];
            sb = srcb[i*RAW +: RAW];
            di = dst[i*RAW +: RAW];
            li = lat[i*LAT_W +: LAT_W];
            ok = lane_valid[i] & mult_ok & (ser_cnt_q == '0);
            if (usea[i] && cnt_q[sa] != '0) ok = 1'b0;
            if (useb[i] && cnt_q[sb] != '0) ok = 1'b0;
            // Writer must not complete before an older in-flight write to the same reg.
            if (regwrite[i] && di != '0 && cnt_q[di] > li) ok = 1'b0;
            if (serial[i] && i != 0) ok = 1'b0;
            for (int j = 0; j < ISSUE_W; j++) begin
                dj = dst[j*RAW +: RAW];
                if (j < i) begin
                    if (serial[j]) ok = 1'b0;
                    if (regwrite[j] && dj != '0 &&
                        ((usea[i] && sa == dj) || (useb[i] && sb == dj)))
                        ok = 1'b0;
                end
            end
            elig[i] = ok;
        end
    end

    // Leading-prefix counts of eligible and of valid lanes.
    always_comb begin
        logic run_e, run_v, gate;
        issued    = '0;
        num_issue = '0;
        num_valid = '0;
        run_e     = 1'b1;
        run_v     = 1'b1;
        gate      = reset | freeze | flush;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (run_e && elig[i] && !gate) begin
                issued[i] = 1'b1;
                num_issue = num_issue + NUM_W'(1);
            end else begin
                run_e = 1'b0;
            end
            if (run_v && lane_valid[i]) begin
                num_valid = num_valid + NUM_W'(1);
            end else begin
                run_v = 1'b0;
            end
        end
    end

    // Decrement-then-load; later lanes overwrite earlier ones on the same dst.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
        end
        ser_cnt_d = (ser_cnt_q != '0) ? ser_cnt_q - SER_W'(1) : '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (issued[i] && regwrite[i] && dst[i*RAW +: RAW] != '0)
                cnt_d[dst[i*RAW +: RAW]] = lat[i*LAT_W +: LAT_W];
            if (issued[i] && serial[i])
                ser_cnt_d = SER_W'(SER_DRAIN);
        end
    end

    always_comb begin
        busy_raw = (ser_cnt_q != '0);
        for (int r = 0; r < NREG; r++) begin
            if (cnt_q[r] != '0) busy_raw = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            ser_cnt_q <= '0;
        end else if (!freeze) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            ser_cnt_q <= ser_cnt_d;
        end
    end

    assign issue_num = num_issue;
    assign stallD    = ~reset & ~flush & (num_issue < num_valid);
    assign flushE    = ~reset & ~freeze & ~flush & (num_issue == '0) & lane_valid[0];
    assign busy      = ~reset & busy_raw;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed test of hazard_scoreboard (ISSUE_W=2) with hand-computed expectations:
//   load-use, in-bundle RAW, register 0, serialisation, freeze/flush, WAW, mult_ok.
module tb_hazard_scoreboard;

    localparam int ISSUE_W = 2;
    localparam int RAW     = 5;
    localparam int LAT_W   = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [ISSUE_W-1:0]       lane_valid;
    logic [ISSUE_W*RAW-1:0]   srca, srcb, dst;
    logic [ISSUE_W-1:0]       usea, useb, regwrite, serial;
    logic [ISSUE_W*LAT_W-1:0] lat;
    logic                     mult_ok, freeze, flush;
    logic [1:0]               issue_num;
    logic                     stallD, flushE, busy;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.ISSUE_W(ISSUE_W), .NREG(32), .RAW(RAW), .LAT_W(LAT_W), .SER_DRAIN(3)) dut (
        .clk(clk), .reset(reset), .lane_valid(lane_valid),
        .srca(srca), .srcb(srcb), .usea(usea), .useb(useb),
        .dst(dst), .regwrite(regwrite), .lat(lat), .serial(serial),
        .mult_ok(mult_ok), .freeze(freeze), .flush(flush),
        .issue_num(issue_num), .stallD(stallD), .flushE(flushE), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_lanes();
        lane_valid = '0; srca = '0; srcb = '0; dst = '0;
        usea = '0; useb = '0; regwrite = '0; serial = '0; lat = '0;
    endtask

    task automatic set_lane(input int i, input int a, input bit ua, input int b, input bit ub,
                            input int d, input bit rw, input int l, input bit ser);
        lane_valid[i]          = 1'b1;
        srca[i*RAW +: RAW]     = a[RAW-1:0];
        usea[i]                = ua;
        srcb[i*RAW +: RAW]     = b[RAW-1:0];
        useb[i]                = ub;
        dst[i*RAW +: RAW]      = d[RAW-1:0];
        regwrite[i]            = rw;
        lat[i*LAT_W +: LAT_W]  = l[LAT_W-1:0];
        serial[i]              = ser;
    endtask

    task automatic expect_out(input string tag, input int n, input int st, input int fe);
        #1;
        check_eq({tag, ".issue_num"}, int'(issue_num), n);
        check_eq({tag, ".stallD"}, int'(stallD), st);
        check_eq({tag, ".flushE"}, int'(flushE), fe);
    endtask

    initial begin
        reset = 1'b1; mult_ok = 1'b1; freeze = 1'b0; flush = 1'b0;
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick(); tick();
        expect_out("reset", 0, 0, 0);
        check_eq("reset.busy", int'(busy), 0);
        reset = 1'b0;
        clr_lanes();
        tick();

        // 1. load-use
        set_lane(0, 0, 0, 0, 0, 3, 1, 2, 0);
        expect_out("lu.c0", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 3, 1, 0, 0, 8, 1, 0, 0);
        expect_out("lu.c1", 0, 1, 1);
        check_eq("lu.busy", int'(busy), 1);
        tick();
        expect_out("lu.c2", 0, 1, 1);
        tick();
        expect_out("lu.c3", 1, 0, 0);
        tick();

        // 2. in-bundle RAW
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 5, 1, 0, 0);
        set_lane(1, 5, 1, 0, 0, 6, 1, 0, 0);
        expect_out("ib.c0", 1, 1, 0);
        tick();
        clr_lanes();
        set_lane(0, 5, 1, 0, 0, 6, 1, 0, 0);
        expect_out("ib.c1", 1, 0, 0);
        tick();

        // 3. register 0
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 0, 1, 3, 0);
        set_lane(1, 0, 1, 0, 1, 10, 1, 0, 0);
        expect_out("r0.c0", 2, 0, 0);
        tick();
        clr_lanes();
        #1;
        check_eq("r0.busy", int'(busy), 0);

        // 4. serialisation
        set_lane(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_out("ser.issue", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 9, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("ser.drain%0d", k), 0, 1, 1);
            check_eq($sformatf("ser.busy%0d", k), int'(busy), 1);
            tick();
        end
        expect_out("ser.resume", 1, 0, 0);
        tick();
        set_lane(1, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_out("ser.lane1", 1, 1, 0);
        tick();

        // 5. freeze then flush
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 7, 1, 3, 0);
        expect_out("fz.lw", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 7, 1, 0, 0, 11, 1, 0, 0);
        freeze = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_out($sformatf("fz.hold%0d", k), 0, 1, 0);
            tick();
        end
        freeze = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("fz.after%0d", k), 0, 1, 1);
            tick();
        end
        expect_out("fz.release", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 7, 1, 3, 0);
        expect_out("fl.lw", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 7, 1, 0, 0, 11, 1, 0, 0);
        flush = 1'b1;
        expect_out("fl.flush", 0, 0, 0);
        tick();
        flush = 1'b0;
        #1;
        check_eq("fl.busy", int'(busy), 0);
        expect_out("fl.reader", 1, 0, 0);
        tick();

        // 6. WAW and mult_ok
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 4, 1, 3, 0);
        expect_out("waw.lw", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 4, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("waw.stall%0d", k), 0, 1, 1);
            tick();
        end
        expect_out("waw.go", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 4, 1, 3, 0);
        expect_out("waw.lw2", 1, 0, 0);
        tick();
        expect_out("waw.eqlat", 1, 0, 0);
        tick();
        clr_lanes();
        set_lane(0, 0, 0, 0, 0, 12, 1, 0, 0);
        set_lane(1, 0, 0, 0, 0, 13, 1, 0, 0);
        mult_ok = 1'b0;
        expect_out("mul.busy", 0, 1, 1);
        mult_ok = 1'b1;
        expect_out("mul.ok", 2, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised issue-hazard unit for a multi-lane, in-order pipeline. It is the successor to the single-lane combinational hazard logic.
- Tracks a per-register pending-latency counter, a serialisation drain counter and a multiply/divide busy condition.
- Each cycle it grants issue to the longest in-order prefix of up to ISSUE_W decode lanes.
- Sits between decode and issue/execute, and drives the stall and flush controls for the decode stage.

Parameters:
ISSUE_W, 2, number of decode lanes examined per cycle (1..4)
NREG, 32, architectural GPR count; register 0 is never pending
RAW, 5, register address width (log2 NREG)
LAT_W, 3, width of the per-instruction result-latency field and of the counters
SER_DRAIN, 3, cycles a serialising op (HI/LO/CP0/TLB write) blocks later issue

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
lane_valid  in  ISSUE_W  lane i holds a decoded instruction
srca  in  ISSUE_W*RAW  source A register, lane i at bits [i*RAW +: RAW]
srcb  in  ISSUE_W*RAW  source B register
usea  in  ISSUE_W  lane reads srca
useb  in  ISSUE_W  lane reads srcb
dst  in  ISSUE_W*RAW  destination register
regwrite  in  ISSUE_W  lane writes dst
lat  in  ISSUE_W*LAT_W  cycles until the result is forwardable (0 = ALU, next-cycle bypass)
serial  in  ISSUE_W  serialising op (hi/lo/cp0 write, tlbr, tlbp)
mult_ok  in  1  multdiv unit idle or result ready
freeze  in  1  backend stall (d-side not data_ok); holds all state
flush  in  1  exception or eret redirect
issue_num  out  $clog2(ISSUE_W+1)  number of lanes issued this cycle, always lanes 0..issue_num-1
stallD  out  1  issue_num < popcount-prefix of lane_valid; decode and fetch must hold
flushE  out  1  a bubble is inserted into execute this cycle
busy  out  1  any counter nonzero

Behaviour:
- Reset: all cnt[r]=0, ser_cnt=0. While reset is high all outputs are 0.
- State:
  - cnt[r] is LAT_W bits per register.
  - ser_cnt counts 0..SER_DRAIN.
  - All hazard checks read registered values only; there is no same-cycle bypass through the counters.
- Lane i is eligible when all of the following hold:
  - lane_valid[i];
  - no RAW on an old write: (!usea[i] or cnt[srca_i]==0) and likewise for srcb;
  - no in-bundle RAW: for every j<i with regwrite[j] and dst_j!=0, lane i does not use dst_j as a source;
  - no WAW ordering conflict: regwrite[i] and dst_i!=0 imply cnt[dst_i] <= lat_i;
  - serialisation: ser_cnt==0, and no serial[j] for any j<i. A serial lane can issue only as lane 0.
  - mult_ok==1.
- issue_num is the count of leading eligible lanes; it stops at the first ineligible lane.
  - Forced to 0 when freeze==1 or flush==1.
- stallD = (issue_num < number of leading valid lanes) & ~flush.
- flushE = ~freeze & ~flush & (issue_num==0) & lane_valid[0]. This bubble replaces the stalled instruction.
- Counter update, on each rising edge with freeze==0 and flush==0:
  - Every nonzero cnt decrements by 1.
  - Then, for each issued lane with regwrite and dst!=0, cnt[dst]=lat.
  - If two issued lanes write the same dst, the higher lane wins.
  - A write to register 0 is ignored.
  - ser_cnt decrements if nonzero; an issued serial lane loads SER_DRAIN.
- freeze==1: all counters hold. Issue is 0.
- flush==1: all cnt and ser_cnt clear to 0 on the next edge. flush has priority over freeze.
- lat is saturating-clipped to 2^LAT_W-1 without error.
- busy = OR of all cnt plus (ser_cnt!=0). It is registered-state derived, with no input path.

Test Plan:
1. Load-use, ISSUE_W=2:
   - Cycle 0: lane0 lw dst=3 lat=2 issues; issue_num=1, because lane1 is invalid.
   - Cycles 1,2: lane0 add srca=3 gives issue_num=0, stallD=1, flushE=1.
   - Cycle 3: issue_num=1.
2. In-bundle RAW:
   - Lane0 add dst=5 lat=0; lane1 sub srca=5 -> issue_num=1.
   - Next cycle, lane1's sub (now in lane0) issues with issue_num=1. cnt[5]==0, so it is not stalled.
3. Register 0:
   - Lane0 dst=0 lat=3; lane1 reads 0 -> issue_num=2, and busy stays 0.
4. Serialisation:
   - Lane0 mtc0 serial issues with issue_num=1.
   - Next 3 cycles: any valid lane gives issue_num=0.
   - 4th cycle: issue resumes.
   - Serial op presented in lane1 -> issue_num=1, only lane0 issues.
5. Freeze and flush:
   - Set cnt[7]=3 via lw lat=3, then freeze=1 for 5 cycles -> cnt[7] stays 3 and issue_num=0.
   - Release freeze, then assert flush for one cycle -> next cycle busy=0, and a reader of r7 issues immediately.
6. WAW and mult_ok:
   - Pending cnt[4]=3. A lane writing r4 with lat=0 stalls until cnt[4]==0, while a write with lat=3 issues.
   - mult_ok=0 gives issue_num=0 regardless of lanes.
